// File: rtl/ftm_buffer_writer_pkg.sv
// ftm_buffer_writer_pkg: shape field layout, channel chunk shift and writer FSM states
package ftm_buffer_writer_pkg;
  localparam int C_MSB = 31;
  localparam int C_LSB = 20;
  localparam int H_MSB = 19;
  localparam int H_LSB = 10;
  localparam int W_MSB = 9;
  localparam int W_LSB = 0;
  localparam int CH_SHIFT = 6;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/ftm_addr_gen.sv
// ftm_addr_gen: off/rx/col_base counter chain sweeping the interleaved bank layout
module ftm_addr_gen #(
  parameter int N_BUF_X = 5,
  parameter int B_DEPTH = 22,
  parameter int B_ADDR = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       adv,
  input  logic [B_DEPTH-1:0]         depth,
  output logic [$clog2(N_BUF_X)-1:0] rx,
  output logic [B_ADDR-1:0]          addr,
  output logic                       column_wrap,
  output logic                       last
);
  localparam int B_RX = $clog2(N_BUF_X);
  logic [B_DEPTH-1:0] off_q;
  logic [B_RX-1:0] rx_q;
  logic [B_ADDR-1:0] col_base_q;
  assign column_wrap = off_q == depth - B_DEPTH'(1);
  assign last = column_wrap && rx_q == B_RX'(N_BUF_X - 1);
  assign rx = rx_q;
  assign addr = col_base_q + B_ADDR'(off_q);
  // off advances per beat; a column wrap steps the bank, a bank wrap moves to the next column block
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      off_q <= '0;
      rx_q <= '0;
      col_base_q <= '0;
    end else if (adv) begin
      off_q <= column_wrap ? '0 : off_q + B_DEPTH'(1);
      if (column_wrap) rx_q <= last ? '0 : rx_q + B_RX'(1);
      if (last) col_base_q <= col_base_q + B_ADDR'(depth);
    end
  end
endmodule

// File: rtl/ftm_buffer_writer.sv
// ftm_buffer_writer: streams a tensor into the column-interleaved feature-map banks
module ftm_buffer_writer
  import ftm_buffer_writer_pkg::*;
#(
  parameter int N_BUF_X = 5,
  parameter int B_BUF_ADDR = 9,
  parameter int B_SHAPE = 32,
  parameter int B_COORD = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [B_SHAPE-1:0]            ftm_shape,
  input  logic                          start,
  input  logic [DATA_WIDTH-1:0]         s_tdata,
  input  logic                          s_tvalid,
  input  logic                          s_tlast,
  output logic                          s_tready,
  output logic [N_BUF_X-1:0]            wren,
  output logic [B_BUF_ADDR*N_BUF_X-1:0] wraddr,
  output logic [DATA_WIDTH-1:0]         wrdata,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);
  localparam int B_C = C_MSB - C_LSB + 1;
  localparam int B_H = H_MSB - H_LSB + 1;
  localparam int B_W = W_MSB - W_LSB + 1;
  localparam int B_DEPTH = B_C + B_H;
  localparam logic [31:0] AMAX = 32'((64'd1 << B_BUF_ADDR) - 64'd1);
  state_t state_q, state_d;
  logic [B_C-1:0] c_q;
  logic [B_H-1:0] h_q;
  logic [B_W-1:0] w_q;
  logic [B_DEPTH-1:0] depth_q, depth_c;
  logic [31:0] total_q, total_c, cnt_q, addr;
  logic end_q, err_q, acc, fin, ovf, cwrap, last;
  logic [$clog2(N_BUF_X)-1:0] rx;
  logic [N_BUF_X-1:0] wren_q;
  logic [B_BUF_ADDR*N_BUF_X-1:0] wraddr_q, wraddr_d;
  logic [DATA_WIDTH-1:0] wrdata_q;
  logic unused_ok;
  assign unused_ok = &{1'b0, cwrap, last, B_COORD > 0};
  assign depth_c = B_DEPTH'(h_q) * B_DEPTH'(c_q >> CH_SHIFT);
  assign total_c = 32'(depth_c) * 32'(w_q);
  assign s_tready = state_q == RUN && !end_q;
  assign acc = s_tvalid && s_tready;
  assign fin = cnt_q == total_q - 32'd1;
  assign ovf = addr > AMAX;
  assign wren = wren_q;
  assign wraddr = wraddr_q;
  assign wrdata = wrdata_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign err = err_q;
  ftm_addr_gen #(.N_BUF_X(N_BUF_X), .B_DEPTH(B_DEPTH), .B_ADDR(32)) u_addr_gen (
    .clk(clk),
    .rst(rst),
    .clr(state_q == IDLE),
    .adv(acc),
    .depth(depth_q),
    .rx(rx),
    .addr(addr),
    .column_wrap(cwrap),
    .last(last)
  );
  // next state; RUN waits one cycle after the final beat so done trails the last write
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = start ? LOAD : IDLE;
      LOAD: state_d = (depth_c == '0 || w_q == '0) ? DONE : RUN;
      RUN: state_d = end_q ? DONE : RUN;
      default: state_d = IDLE;
    endcase
  end
  // only the addressed bank's slice carries an address; suppressed writes leave all slices zero
  always_comb begin
    wraddr_d = '0;
    if (acc && !ovf) wraddr_d[rx*B_BUF_ADDR +: B_BUF_ADDR] = addr[B_BUF_ADDR-1:0];
  end
  // state, latched shape, beat bookkeeping, error flag and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q <= '0;
      h_q <= '0;
      w_q <= '0;
      depth_q <= '0;
      total_q <= '0;
      cnt_q <= '0;
      end_q <= 1'b0;
      err_q <= 1'b0;
      wren_q <= '0;
      wraddr_q <= '0;
      wrdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        c_q <= ftm_shape[C_MSB:C_LSB];
        h_q <= ftm_shape[H_MSB:H_LSB];
        w_q <= ftm_shape[W_MSB:W_LSB];
      end
      if (state_q == LOAD) begin
        depth_q <= depth_c;
        total_q <= total_c;
      end
      cnt_q <= state_q == IDLE ? '0 : cnt_q + 32'(acc);
      end_q <= state_q == IDLE ? 1'b0 : end_q | (acc && (fin || s_tlast));
      err_q <= (state_q == IDLE && start) ? 1'b0 : err_q | (acc && (ovf || s_tlast != fin));
      wren_q <= (acc && !ovf) ? N_BUF_X'(1) << rx : '0;
      wraddr_q <= wraddr_d;
      wrdata_q <= acc ? s_tdata : '0;
    end
  end
endmodule

// File: tb/tb_ftm_buffer_writer.sv
// tb_ftm_buffer_writer: scoreboard bench for the feature-map buffer writer
module tb_ftm_buffer_writer;
  localparam int NB = 5;
  localparam int AW = 9;
  typedef struct {
    int bank;
    int addr;
    logic [63:0] data;
  } exp_t;
  logic clk = 0, rst = 1, start = 0, s_tvalid = 0, s_tlast = 0;
  logic [31:0] ftm_shape = 0;
  logic [63:0] s_tdata = 0;
  logic s_tready, busy, done, err;
  logic [NB-1:0] wren;
  logic [AW*NB-1:0] wraddr;
  logic [63:0] wrdata;
  int total = 0, bad = 0, cyc = 0, st_cyc = 0, last_wr_cyc = 0, ndone = 0, m_depth = 0;
  bit rdy_seen = 0;
  exp_t q[$];
  exp_t e;

  ftm_buffer_writer dut (
    .clk(clk), .rst(rst), .ftm_shape(ftm_shape), .start(start),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .wren(wren), .wraddr(wraddr), .wrdata(wrdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (s_tready) rdy_seen = 1;
    if (done) ndone++;
    if (wren != 0) begin
      if (q.size() == 0) chk("unexp_wr", 64'(wren), 64'd0);
      else begin
        e = q.pop_front();
        chk("wren", 64'(wren), 64'd1 << e.bank);
        chk("wraddr", 64'(wraddr), 64'(e.addr) << (e.bank * AW));
        chk("wrdata", wrdata, e.data);
        last_wr_cyc = cyc;
      end
    end
  end

  task automatic start_load(input int c, input int h, input int w);
    @(posedge clk); #1;
    ftm_shape = {12'(c), 10'(h), 10'(w)};
    start = 1;
    st_cyc = cyc;
    rdy_seen = 0;
    ndone = 0;
    m_depth = h * (c / 64);
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("err_clr", 64'(err), 64'd0);
    chk("busy_on", 64'(busy), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic drive(input int nsend, input int tlast_at, input int vpct);
    int sent = 0;
    int n = 0;
    int a;
    while (sent < nsend && n < 20000) begin
      s_tvalid = $urandom_range(99) < vpct;
      s_tdata = {$urandom, $urandom};
      s_tlast = s_tvalid && sent == tlast_at;
      @(negedge clk);
      if (s_tvalid && s_tready) begin
        a = m_depth * (sent / (m_depth * NB)) + sent % m_depth;
        if (a < (1 << AW)) q.push_back('{(sent / m_depth) % NB, a, s_tdata});
        sent++;
      end
      @(posedge clk); #1;
      n++;
    end
    s_tvalid = 0;
    s_tlast = 0;
    chk("beats", 64'(sent), 64'(nsend));
  endtask

  task automatic wait_done(input int exp_err, input int mode, input bit restart);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20000);
    chk("done", 64'(done), 64'd1);
    if (mode == 1) chk("done_lat_wr", 64'(cyc - last_wr_cyc), 64'd1);
    if (mode == 2) chk("done_lat_start", 64'(cyc - st_cyc), 64'd2);
    if (restart) begin
      start = 1;
      @(posedge clk); #1;
      start = 0;
      @(negedge clk);
      chk("start_at_done", 64'(busy), 64'd0);
    end
    repeat (3) @(negedge clk);
    chk("err", 64'(err), 64'(exp_err));
    chk("ndone", 64'(ndone), 64'd1);
    chk("q_empty", 64'(q.size()), 64'd0);
    chk("busy_off", 64'(busy), 64'd0);
    chk("rdy_off", 64'(s_tready), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wren", 64'(wren), 64'd0);
    chk("rst_wraddr", 64'(wraddr), 64'd0);
    chk("rst_wrdata", wrdata, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdy", 64'(s_tready), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    start_load(128, 4, 7);
    drive(56, 55, 100);
    wait_done(0, 1, 1);
    start_load(128, 4, 7);
    fork
      drive(56, 55, 50);
      begin
        repeat (20) @(posedge clk);
        #1;
        ftm_shape = {12'd64, 10'd2, 10'd3};
        start = 1;
        @(posedge clk); #1;
        start = 0;
      end
    join
    wait_done(0, 1, 0);
    start_load(32, 4, 7);
    wait_done(0, 2, 0);
    chk("zero_rdy", 64'(rdy_seen), 64'd0);
    start_load(100, 3, 6);
    drive(18, 17, 70);
    wait_done(0, 1, 0);
    start_load(128, 4, 7);
    drive(21, 20, 100);
    wait_done(1, 1, 0);
    start_load(128, 4, 7);
    drive(56, -1, 100);
    wait_done(1, 1, 0);
    start_load(640, 64, 10);
    drive(6400, 6399, 100);
    wait_done(1, 0, 0);
    start_load(128, 4, 7);
    drive(30, -1, 100);
    rst = 1;
    s_tvalid = 1;
    s_tdata = {$urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_wren", 64'(wren), 64'd0);
    chk("mid_rst_wraddr", 64'(wraddr), 64'd0);
    chk("mid_rst_wrdata", wrdata, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_rdy", 64'(s_tready), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    s_tvalid = 0;
    repeat (6) @(negedge clk);
    chk("mid_rst_nodone", 64'(ndone), 64'd0);
    chk("mid_rst_q", 64'(q.size()), 64'd0);
    chk("mid_rst_idle", 64'(busy), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
